// File: rtl/reaction_timer_if.sv
// Button-side inputs and display-side outputs of the reaction timer core.
// The master drives the buttons and the slave is the timing engine.
interface reaction_timer_if #(
  parameter int TIME_W = 14
);
  logic              start;
  logic              react;
  logic              led;
  logic [2:0]        state;
  logic [TIME_W-1:0] time_ms;
  logic [TIME_W-1:0] best_ms;
  logic              done;
  logic              false_start;
  logic              timeout;
  logic [7:0]        trials;

  modport master (
    output start, react,
    input  led, state, time_ms, best_ms,
    input  done, false_start, timeout, trials
  );

  modport slave (
    input  start, react,
    output led, state, time_ms, best_ms,
    output done, false_start, timeout, trials
  );
endinterface

// File: rtl/reaction_timer_core.sv
// Reaction-time engine: idle, random hold-off, timed window, result.
// Tracks best time and trial count, flags false starts and timeouts.
module reaction_timer_core #(
  parameter int CLK_HZ    = 100000000,
  parameter int TICK_HZ   = 1000,
  parameter int MIN_DELAY = 1000,
  parameter int RAND_BITS = 11,
  parameter int TIME_W    = 14,
  parameter int MAX_TIME  = 9999
) (
  input logic              clk,
  input logic              rst,
  reaction_timer_if.slave  bus
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (MIN_DELAY + 2**RAND_BITS - 1 >= 65536) begin : g_bad_delay
    $error("hold-off range does not fit the 16-bit delay counter");
  end
  if (MAX_TIME >= 2**TIME_W - 1) begin : g_bad_max
    $error("MAX_TIME must be below 2^TIME_W-1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_REACT = 3'd2,
    S_DONE  = 3'd3,
    S_FALSE = 3'd4,
    S_TOUT  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic              start_d_q, react_d_q;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       tgt_q, tgt_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [TIME_W-1:0] best_q, best_d;
  logic [7:0]        trials_q, trials_d;
  logic              led_q, led_d;
  logic              done_q, done_d;
  logic              start_rise, react_rise, tick;

  assign start_rise = bus.start & ~start_d_q;
  assign react_rise = bus.react & ~react_d_q;
  assign tick = (DIV == 1) || (pre_q == PW'(DIV - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tgt_d    = tgt_q;
    time_d   = time_q;
    best_d   = best_q;
    lfsr_d   = {lfsr_q[14:0],
                lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    case (state_q)
      S_IDLE, S_DONE, S_FALSE, S_TOUT: begin
        if (state_q == S_DONE && time_q < best_q) best_d = time_q;
        if (start_rise) begin
          state_d = S_WAIT;
          tgt_d   = 16'(MIN_DELAY) + 16'(lfsr_q[RAND_BITS-1:0]);
          cnt_d   = '0;
          time_d  = '0;
        end
      end
      S_WAIT: begin
        if (react_rise) begin
          state_d = S_FALSE;
        end else if (tick) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == tgt_q) state_d = S_REACT;
        end
      end
      S_REACT: begin
        // a press in the same cycle as a tick freezes the count
        if (react_rise) begin
          state_d = S_DONE;
        end else if (tick) begin
          if (time_q >= TIME_W'(MAX_TIME - 1)) begin
            time_d  = TIME_W'(MAX_TIME);
            state_d = S_TOUT;
          end else begin
            time_d = time_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    led_d    = (state_d == S_REACT);
    done_d   = (state_d == S_DONE) && (state_q != S_DONE);
    trials_d = trials_q;
    if (done_d && trials_q != 8'hFF) trials_d = trials_q + 8'd1;

    pre_d = pre_q + 1'b1;
    if (tick) pre_d = '0;
    if (state_d != state_q &&
        (state_d == S_WAIT || state_d == S_REACT)) pre_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      start_d_q <= 1'b1;
      react_d_q <= 1'b1;
      lfsr_q    <= 16'hACE1;
      pre_q     <= '0;
      cnt_q     <= '0;
      tgt_q     <= '0;
      time_q    <= '0;
      best_q    <= '1;
      trials_q  <= '0;
      led_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_d_q <= bus.start;
      react_d_q <= bus.react;
      lfsr_q    <= lfsr_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      time_q    <= time_d;
      best_q    <= best_d;
      trials_q  <= trials_d;
      led_q     <= led_d;
      done_q    <= done_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.led         = led_q;
  assign bus.time_ms     = time_q;
  assign bus.best_ms     = best_q;
  assign bus.done        = done_q;
  assign bus.false_start = (state_q == S_FALSE);
  assign bus.timeout     = (state_q == S_TOUT);
  assign bus.trials      = trials_q;

endmodule
